// File: rtl/cache_fill_ctrl_if.sv
// Bus bundle between a cache fill controller, its cache lookup logic,
// main memory and the cache data/tag arrays.
interface cache_fill_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 8
) ();
    localparam int IDX_W = $clog2(WORDS);

    logic              miss_detected;
    logic [ADDR_W-1:0] miss_address;
    logic              fsm_busy;
    logic              memory_req;
    logic [ADDR_W-1:0] memory_address;
    logic              memory_data_valid;
    logic [DATA_W-1:0] memory_data;
    logic              write_data_array;
    logic [IDX_W-1:0]  fill_word;
    logic [DATA_W-1:0] fill_data;
    logic              write_tag_array;
    logic [ADDR_W-1:0] fill_base;

    // Controller side
    modport master (
        input  miss_detected, miss_address, memory_data_valid, memory_data,
        output fsm_busy, memory_req, memory_address, write_data_array,
               fill_word, fill_data, write_tag_array, fill_base
    );

    // Environment side (cache lookup, memory, arrays)
    modport slave (
        output miss_detected, miss_address, memory_data_valid, memory_data,
        input  fsm_busy, memory_req, memory_address, write_data_array,
               fill_word, fill_data, write_tag_array, fill_base
    );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Cache-miss fill controller: on a miss, fetches one aligned block from a
// pipelined main memory one word per request, writes each returned word into
// the data array and writes the tag together with the last word.
module cache_fill_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 8
) (
    input  logic             clk,
    input  logic             rst,
    cache_fill_ctrl_if.master bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(WORDS * BYTES);
    localparam int IDX_W = $clog2(WORDS);
    localparam int CNT_W = IDX_W + 1;

    localparam logic [CNT_W-1:0]  WORDS_C = CNT_W'(WORDS);
    localparam logic [IDX_W-1:0]  LAST_C  = IDX_W'(WORDS - 1);
    localparam logic [ADDR_W-1:0] BYTES_A = ADDR_W'(BYTES);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  req_cnt_q, req_cnt_d;
    logic [IDX_W-1:0]  rcv_cnt_q, rcv_cnt_d;
    logic [ADDR_W-1:0] fill_base_q, fill_base_d;
    logic              memory_req_q, memory_req_d;

    logic              busy_s;
    logic              write_data_s;
    logic              write_tag_s;
    logic [ADDR_W-1:0] address_s;

    // Next-state, counter updates and decoded strobes
    always_comb begin
        state_d      = state_q;
        req_cnt_d    = req_cnt_q;
        rcv_cnt_d    = rcv_cnt_q;
        fill_base_d  = fill_base_q;
        busy_s       = 1'b0;
        write_data_s = 1'b0;
        write_tag_s  = 1'b0;
        address_s    = {ADDR_W{1'b0}};

        case (state_q)
            IDLE: begin
                // Stall goes up in the same cycle the miss is seen; any
                // memory_data_valid here is stale and ignored.
                busy_s = bus.miss_detected;
                if (bus.miss_detected) begin
                    state_d     = FILL;
                    fill_base_d = {bus.miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    req_cnt_d   = {CNT_W{1'b0}};
                    rcv_cnt_d   = {IDX_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            FILL: begin
                busy_s = 1'b1;
                // Requests go out back-to-back regardless of responses.
                if (memory_req_q) begin
                    req_cnt_d = req_cnt_q + CNT_W'(1);
                    address_s = fill_base_q + (ADDR_W'(req_cnt_q) * BYTES_A);
                end else begin
                    req_cnt_d = req_cnt_q;
                end
                // Responses are counted, not timed: latency is unknown.
                if (bus.memory_data_valid) begin
                    write_data_s = 1'b1;
                    rcv_cnt_d    = rcv_cnt_q + IDX_W'(1);
                    if (rcv_cnt_q == LAST_C) begin
                        write_tag_s = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        state_d = FILL;
                    end
                end else begin
                    rcv_cnt_d = rcv_cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        memory_req_d = (state_d == FILL) && (req_cnt_d < WORDS_C);
    end

    // State, counters, latched block base and request-valid flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            req_cnt_q    <= {CNT_W{1'b0}};
            rcv_cnt_q    <= {IDX_W{1'b0}};
            fill_base_q  <= {ADDR_W{1'b0}};
            memory_req_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_cnt_q    <= req_cnt_d;
            rcv_cnt_q    <= rcv_cnt_d;
            fill_base_q  <= fill_base_d;
            memory_req_q <= memory_req_d;
        end
    end

    assign bus.fsm_busy         = busy_s;
    assign bus.memory_req       = memory_req_q;
    assign bus.memory_address   = address_s;
    assign bus.write_data_array = write_data_s;
    assign bus.fill_word        = rcv_cnt_q;
    assign bus.fill_data        = bus.memory_data;
    assign bus.write_tag_array  = write_tag_s;
    assign bus.fill_base        = fill_base_q;
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Self-checking bench for cache_fill_ctrl: table-driven idle/miss vectors,
// randomized fills against a block-level reference model, and hand-written
// sequences for wrap-around, mid-fill reset and a 4-word/32-bit instance.
module tb_cache_fill_ctrl;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int WORDS  = 8;
    localparam int BYTES  = DATA_W / 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_fill_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS)) bus ();
    cache_fill_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    cache_fill_ctrl_if #(.ADDR_W(16), .DATA_W(32), .WORDS(4)) bus2 ();
    cache_fill_ctrl #(.ADDR_W(16), .DATA_W(32), .WORDS(4)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    typedef struct packed {
        logic        miss;
        logic [15:0] addr;
        logic        fv;
        logic        e_busy;
        logic        e_req;
        logic        e_wr;
        logic        e_tag;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model: one block fill at a time, described by its base,
    // how many requests have gone out and how many words have come back.
    bit          m_fill;
    logic [15:0] m_base;
    int          m_reqs;
    int          m_words;
    int          cyc;

    // Memory model: in-order responses, fixed latency, random gaps.
    int          pend_due[$];
    logic [15:0] pend_addr[$];
    int          lat;
    int          gap_pct;
    int          obs_wr;
    int          obs_tag;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
    task automatic cycle(input logic miss, input logic [15:0] maddr, input bit force_v,
                         input bit use_tbl, input vec_t v);
        logic        v_s;
        logic [15:0] d_s;
        logic        e_busy, e_req, e_wr, e_tag;
        bus.miss_detected = miss;
        bus.miss_address  = maddr;
        v_s = 1'b0;
        d_s = 16'($urandom);
        if (force_v) begin
            v_s = 1'b1;
        end else if (pend_due.size() > 0 && pend_due[0] <= cyc &&
                     $urandom_range(0, 99) >= gap_pct) begin
            v_s = 1'b1;
            d_s = mem_word(pend_addr[0]);
            void'(pend_due.pop_front());
            void'(pend_addr.pop_front());
        end
        bus.memory_data_valid = v_s;
        bus.memory_data       = d_s;
        #1;
        e_busy = m_fill | miss;
        e_req  = m_fill && (m_reqs < WORDS);
        e_wr   = m_fill && v_s;
        e_tag  = e_wr && (m_words == WORDS - 1);
        chk("busy", bus.fsm_busy, e_busy);
        chk("mem_req", bus.memory_req, e_req);
        chk("wr_data", bus.write_data_array, e_wr);
        chk("wr_tag", bus.write_tag_array, e_tag);
        chk("fill_base", bus.fill_base, m_base);
        if (e_req)
            chk("mem_addr", bus.memory_address, 16'(m_base + 16'(m_reqs * BYTES)));
        if (e_wr) begin
            chk("fill_word", bus.fill_word, m_words);
            chk("fill_data", bus.fill_data, mem_word(16'(m_base + 16'(m_words * BYTES))));
        end
        if (use_tbl) begin
            chk("tbl_busy", bus.fsm_busy, v.e_busy);
            chk("tbl_req", bus.memory_req, v.e_req);
            chk("tbl_wr", bus.write_data_array, v.e_wr);
            chk("tbl_tag", bus.write_tag_array, v.e_tag);
        end
        if (bus.memory_req) begin
            pend_due.push_back(cyc + lat);
            pend_addr.push_back(bus.memory_address);
        end
        obs_wr  += int'(bus.write_data_array);
        obs_tag += int'(bus.write_tag_array);
        @(posedge clk);
        if (!m_fill && miss) begin
            m_fill  = 1'b1;
            m_base  = maddr & ~16'(WORDS * BYTES - 1);
            m_reqs  = 0;
            m_words = 0;
        end else if (m_fill) begin
            if (e_req) m_reqs++;
            if (v_s) begin
                m_words++;
                if (m_words == WORDS) m_fill = 1'b0;
            end
        end
        cyc++;
        #1;
    endtask

    // Run an already accepted fill to completion within a cycle budget.
    task automatic finish_fill(input bit hold, input bit rnd, input logic [15:0] addr);
        vec_t nov;
        int   n;
        logic mi;
        nov = '0;
        n   = 0;
        while (m_fill && n < 300) begin
            mi = hold | (rnd & ($urandom_range(0, 1) == 1));
            cycle(mi, hold ? addr : 16'($urandom), 1'b0, 1'b0, nov);
            n++;
        end
        if (m_fill) begin
            checks++;
            errors++;
            $display("FAIL fill_timeout: still filling after %0d cycles", n);
            m_fill = 1'b0;
        end
        chk("fill_writes", obs_wr, WORDS);
        chk("fill_tags", obs_tag, 1);
    endtask

    task automatic run_fill(input logic [15:0] addr, input bit hold, input bit rnd);
        vec_t nov;
        nov     = '0;
        obs_wr  = 0;
        obs_tag = 0;
        cycle(1'b1, addr, 1'b0, 1'b0, nov);
        finish_fill(hold, rnd, addr);
    endtask

    vec_t tbl[6];
    vec_t nov0;

    initial begin
        nov0    = '0;
        m_fill  = 1'b0;
        m_base  = 16'h0000;
        m_reqs  = 0;
        m_words = 0;
        cyc     = 0;
        lat     = 4;
        gap_pct = 0;
        obs_wr  = 0;
        obs_tag = 0;

        //            miss  addr      fv    busy  req   wr    tag
        tbl[0] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 16'h1236, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 16'h1236, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        bus.miss_detected      = 1'b0;
        bus.miss_address       = 16'h0000;
        bus.memory_data_valid  = 1'b0;
        bus.memory_data        = 16'h0000;
        bus2.miss_detected     = 1'b0;
        bus2.miss_address      = 16'h0000;
        bus2.memory_data_valid = 1'b0;
        bus2.memory_data       = 32'h0;

        rst = 1'b1;
        #2;
        chk("rst_busy", bus.fsm_busy, 1'b0);
        chk("rst_req", bus.memory_req, 1'b0);
        chk("rst_addr", bus.memory_address, 16'h0000);
        chk("rst_wr", bus.write_data_array, 1'b0);
        chk("rst_tag", bus.write_tag_array, 1'b0);
        chk("rst_word", bus.fill_word, 3'd0);
        chk("rst_base", bus.fill_base, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle with stray valid pulses, then the 0x1236 miss (latency 4).
        for (int i = 0; i < 6; i++)
            cycle(tbl[i].miss, tbl[i].addr, tbl[i].fv, 1'b1, tbl[i]);
        finish_fill(1'b0, 1'b0, 16'h0000);

        // Randomized fills: random latency, gaps and misses during fill.
        gap_pct = 50;
        for (int f = 0; f < 8; f++) begin
            lat = $urandom_range(1, 6);
            run_fill(16'($urandom), 1'b0, 1'b1);
            repeat ($urandom_range(0, 2)) cycle(1'b0, 16'h0000, 1'b0, 1'b0, nov0);
        end

        // Miss held through a fill at the top of the address space.
        gap_pct = 20;
        lat     = 3;
        run_fill(16'hFFF2, 1'b1, 1'b0);
        chk("wrap_base", bus.fill_base, 16'hFFF0);
        run_fill(16'hFFF2, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b0, nov0);

        // Reset after three received words abandons the fill.
        gap_pct = 0;
        lat     = 2;
        obs_tag = 0;
        cycle(1'b1, 16'h2468, 1'b0, 1'b0, nov0);
        for (int n = 0; n < 40 && m_words < 3; n++)
            cycle(1'b0, 16'h0000, 1'b0, 1'b0, nov0);
        chk("pre_rst_tags", obs_tag, 0);
        bus.miss_detected     = 1'b0;
        bus.memory_data_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", bus.fsm_busy, 1'b0);
        chk("mid_rst_req", bus.memory_req, 1'b0);
        chk("mid_rst_addr", bus.memory_address, 16'h0000);
        chk("mid_rst_word", bus.fill_word, 3'd0);
        chk("mid_rst_base", bus.fill_base, 16'h0000);
        chk("mid_rst_tag", bus.write_tag_array, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_fill = 1'b0;
        m_base = 16'h0000;
        pend_due.delete();
        pend_addr.delete();
        cyc++;
        cycle(1'b0, 16'h0000, 1'b0, 1'b0, nov0);
        run_fill(16'h0040, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b0, nov0);

        // Four 32-bit words per block: miss at 0x0107, latency 2.
        bus2.miss_detected = 1'b1;
        bus2.miss_address  = 16'h0107;
        #1;
        chk("w4_busy_miss", bus2.fsm_busy, 1'b1);
        chk("w4_req_miss", bus2.memory_req, 1'b0);
        @(posedge clk);
        #1;
        bus2.miss_detected = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus2.memory_data_valid = (k >= 2 && k < 6);
            bus2.memory_data       = 32'hA500_0000 + 32'(k);
            #1;
            chk("w4_req", bus2.memory_req, k < 4);
            if (k < 4) chk("w4_addr", bus2.memory_address, 16'h0100 + 16'(4 * k));
            chk("w4_wr", bus2.write_data_array, k >= 2 && k < 6);
            if (k >= 2 && k < 6) begin
                chk("w4_word", bus2.fill_word, k - 2);
                chk("w4_data", bus2.fill_data, 32'hA500_0000 + 32'(k));
            end
            chk("w4_tag", bus2.write_tag_array, k == 5);
            chk("w4_busy", bus2.fsm_busy, k <= 5);
            chk("w4_base", bus2.fill_base, 16'h0100);
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
- Parametrised cache-miss fill controller. It is the next step after the single-cycle memory1c path, where the pipeline reads instruction and data memory directly.
- On a miss it fetches one whole cache block from a pipelined, multi-cycle main memory, one word per request. Each returning word is written into the cache data array, and the tag array is written with the final word.
- One instance sits beside the I-cache and one beside the D-cache. `fsm_busy` stalls the pipeline while a fill is in progress.

Parameters:
- ADDR_W, 16, byte-address width.
- DATA_W, 16, word width in bits; a multiple of 8. BYTES = DATA_W/8.
- WORDS, 8, words per block; a power of two, at least 2.
- OFF_W, $clog2(WORDS*BYTES), block-offset bits. Derived; do not override.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- miss_detected  in  1  cache lookup missed this cycle; sampled only in IDLE.
- miss_address  in  ADDR_W  byte address of the missing access.
- fsm_busy  out  1  fill in progress; pipeline stall request.
- memory_req  out  1  request valid to main memory.
- memory_address  out  ADDR_W  byte address of the current request.
- memory_data_valid  in  1  main memory returning a word this cycle.
- memory_data  in  DATA_W  returned word.
- write_data_array  out  1  write `fill_data` into the data array at `fill_word`.
- fill_word  out  $clog2(WORDS)  word index within the block for the current write.
- fill_data  out  DATA_W  word to write; equals `memory_data`.
- write_tag_array  out  1  write the tag and set valid for `fill_base`.
- fill_base  out  ADDR_W  block base address, i.e. `miss_address` with the low OFF_W bits cleared.

Behaviour:
- States: IDLE and FILL. Registered counters:
  - `req_cnt`, 0..WORDS, counts requests issued.
  - `rcv_cnt`, 0..WORDS-1, counts words received.
- Reset (async, any state, including mid-fill):
  - state=IDLE, `req_cnt`=0, `rcv_cnt`=0, `fill_base`=0.
  - All outputs 0; `memory_address`=0.
  - A fill interrupted by reset is abandoned. Data words already written stay in the array; the tag is not written.
- `fsm_busy` is combinational: (state==FILL) | (state==IDLE & miss_detected). The stall is therefore raised in the same cycle the miss is seen.
- IDLE → FILL when `miss_detected`=1:
  - Latch `fill_base` = {miss_address[ADDR_W-1:OFF_W], OFF_W'b0}.
  - Clear both counters.
- In IDLE, `memory_data_valid` is ignored; no array writes occur.
- FILL, request side:
  - `memory_req` = (req_cnt < WORDS).
  - `memory_address` = fill_base + req_cnt*BYTES.
  - `req_cnt` increments each cycle `memory_req` is high.
  - Requests issue back-to-back: exactly WORDS requests, on the first WORDS cycles of FILL.
- FILL, response side, when `memory_data_valid`=1:
  - `write_data_array`=1, `fill_word`=rcv_cnt, `fill_data`=memory_data.
  - `rcv_cnt` increments.
- When `memory_data_valid`=1 and rcv_cnt==WORDS-1:
  - `write_tag_array`=1 in that same cycle.
  - Next state is IDLE and `fsm_busy` drops on the following cycle.
- The controller does not assume any memory latency; it counts valid responses. Responses may overlap issuing, i.e. arrive while `req_cnt` < WORDS.
- `miss_detected` during FILL is ignored. A new miss can be accepted in the first IDLE cycle after the tag write.
- `memory_data_valid` arriving in the cycle of the IDLE→FILL transition is ignored. Memory only responds to requests, so this cannot be a valid word.
- Address arithmetic wraps modulo 2^ADDR_W. The block never crosses its aligned boundary, because the offset bits are always below WORDS*BYTES.
- All outputs other than `fsm_busy`, `fill_data`, `memory_address` and the write strobes are registered. The write strobes are decoded from state plus `memory_data_valid`.

Test Plan:
- Reset, then hold idle 5 cycles → all outputs 0; `fsm_busy`=0; `memory_data_valid` pulses produce no writes.
- Defaults; miss at 0x1236; memory with latency 4 → `fsm_busy`=1 in the miss cycle. `memory_req` high for 8 consecutive cycles with addresses 0x1230, 0x1232, …, 0x123E. 8 data writes follow with `fill_word` 0..7. `write_tag_array`=1 only with word 7, `fill_base`=0x1230, then IDLE.
- Gappy memory: valid deasserted randomly between words → exactly 8 data writes in order 0..7. Busy holds until the 8th; requests are unaffected.
- `miss_detected` held high through an entire fill at 0xFFF2 → `fill_base`=0xFFF0 with addresses 0xFFF0..0xFFFE. No restart mid-fill; a second fill starts the cycle after IDLE is re-entered.
- Assert `rst` after 3 received words → next edge-independent outputs are 0 and state is IDLE. No tag write occurs; a fresh miss at 0x0040 restarts at word 0.
- WORDS=4, DATA_W=32 → miss at 0x0107 gives base 0x0100 and addresses 0x0100, 0x0104, 0x0108, 0x010C.
